// File: rtl/prv664_vm_pkg.sv
// Shared types and constants for the supervisor address-translation control.
// Optional SV48 support is selected with VIRTUAL_TRANS_SV48_EN.
package prv664_vm_pkg;

  localparam int XLEN = 64;
  localparam logic [11:0] CSR_SATP = 12'h180;

  localparam int SATP_MODE_LSB = 60;
  localparam int SATP_ASID_LSB = 44;
  localparam int SATP_PPN_LSB  = 0;

  typedef enum logic [3:0] {
    SATP_BARE = 4'd0,
    SATP_SV39 = 4'd8,
    SATP_SV48 = 4'd9
  } satp_mode_e;

  typedef struct packed {
    logic            all;
    logic            va_v;
    logic            asid_v;
    logic [XLEN-1:0] vaddr;
    logic [15:0]     asid;
  } vt_flush_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // MODE is WARL: anything not listed here leaves the current MODE in place.
  function automatic logic mode_legal(input logic [3:0] m);
    logic ok;
    ok = (m == SATP_BARE) || (m == SATP_SV39);
`ifdef VIRTUAL_TRANS_SV48_EN
    ok = ok || (m == SATP_SV48);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/vt_ack_collect.sv
// Pending-acknowledge tracker: all channels armed on start, each cleared by its ack.
module vt_ack_collect #(
  parameter int NCH = 2
) (
  input  logic           clk_i,
  input  logic           arst_ni,
  input  logic           start_i,
  input  logic [NCH-1:0] ack_i,
  output logic [NCH-1:0] pending_o,
  output logic           done_o
);

  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] remain;

  assign remain = pending_q & ~ack_i;

  always_comb begin
    pending_d = remain;
    if (start_i) pending_d = '1;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  assign pending_o = pending_q;
  // High in the last cycle of a flush: nothing is left once this cycle's acks land.
  assign done_o    = (remain == '0);

endmodule

// File: rtl/virtual_trans_ctrl.sv
// satp register and TLB flush sequencer; SV48 acceptance via VIRTUAL_TRANS_SV48_EN.
//   state    | meaning
//   IDLE     | accepting satp writes and sfence.vma commits
//   FLUSH    | flush requests outstanding, commits ignored, busy_o high
module virtual_trans_ctrl
  import prv664_vm_pkg::*;
#(
  parameter int ASID_WIDTH = 9,
  parameter int PPN_WIDTH  = 44,
  parameter int NCH        = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  valid,
  input  logic [11:0]           csrindex,
  input  logic [XLEN-1:0]       csrdata,
  input  logic                  csren,
  input  logic                  sfence_i,
  input  logic                  sfence_rs1z_i,
  input  logic                  sfence_rs2z_i,
  input  logic [XLEN-1:0]       sfence_vaddr_i,
  input  logic [15:0]           sfence_asid_i,
  output logic [XLEN-1:0]       satp,
  output logic                  busy_o,
  output logic [NCH-1:0]        flush_req_o,
  output logic                  flush_all_o,
  output logic                  flush_va_o,
  output logic                  flush_asid_o,
  output logic [XLEN-1:0]       flush_vaddr_o,
  output logic [ASID_WIDTH-1:0] flush_asidv_o,
  input  logic [NCH-1:0]        flush_ack_i
);

  logic [0:0]            state_q, state_d;
  logic [3:0]            mode_q, mode_d;
  logic [ASID_WIDTH-1:0] asid_q, asid_d;
  logic [PPN_WIDTH-1:0]  ppn_q, ppn_d;
  vt_flush_t             flush_q, flush_d;

  logic idle, satp_wr, sfence_cmt, start, done;
  logic unused_bits;

  assign idle       = (state_q == ST_IDLE);
  assign satp_wr    = idle & valid & csren & (csrindex == CSR_SATP);
  assign sfence_cmt = idle & valid & sfence_i;
  assign start      = satp_wr | sfence_cmt;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    asid_d  = asid_q;
    ppn_d   = ppn_q;
    flush_d = flush_q;

    if (satp_wr) begin
      if (mode_legal(csrdata[SATP_MODE_LSB +: 4])) mode_d = csrdata[SATP_MODE_LSB +: 4];
      asid_d = csrdata[SATP_ASID_LSB +: ASID_WIDTH];
      ppn_d  = csrdata[SATP_PPN_LSB +: PPN_WIDTH];
    end

    // A satp write always wins: a new root/ASID invalidates every cached entry.
    if (satp_wr) begin
      flush_d.all    = 1'b1;
      flush_d.va_v   = 1'b0;
      flush_d.asid_v = 1'b0;
      flush_d.vaddr  = '0;
      flush_d.asid   = '0;
    end else if (sfence_cmt) begin
      flush_d.all    = sfence_rs1z_i & sfence_rs2z_i;
      flush_d.va_v   = ~sfence_rs1z_i;
      flush_d.asid_v = ~sfence_rs2z_i;
      flush_d.vaddr  = sfence_vaddr_i;
      flush_d.asid   = '0;
      flush_d.asid[ASID_WIDTH-1:0] = sfence_asid_i[ASID_WIDTH-1:0];
    end

    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FLUSH;
      ST_FLUSH: if (done)  state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_IDLE;
      mode_q  <= SATP_BARE;
      asid_q  <= '0;
      ppn_q   <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      asid_q  <= asid_d;
      ppn_q   <= ppn_d;
      flush_q <= flush_d;
    end
  end

  vt_ack_collect #(.NCH(NCH)) u_ack (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .start_i   (start),
    .ack_i     (flush_ack_i),
    .pending_o (flush_req_o),
    .done_o    (done)
  );

  always_comb begin
    satp = '0;
    satp[SATP_MODE_LSB +: 4]          = mode_q;
    satp[SATP_ASID_LSB +: ASID_WIDTH] = asid_q;
    satp[SATP_PPN_LSB +: PPN_WIDTH]   = ppn_q;
  end

  assign busy_o        = (state_q == ST_FLUSH);
  assign flush_all_o   = flush_q.all;
  assign flush_va_o    = flush_q.va_v;
  assign flush_asid_o  = flush_q.asid_v;
  assign flush_vaddr_o = flush_q.vaddr;
  assign flush_asidv_o = flush_q.asid[ASID_WIDTH-1:0];

  assign unused_bits = ^{csrdata, sfence_asid_i, flush_q.asid};

endmodule

// File: tb/tb_virtual_trans_ctrl.sv
// Scoreboard bench for virtual_trans_ctrl: commits push expected flushes, a monitor checks them.
module tb_virtual_trans_ctrl;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        valid = 1'b0;
  logic [11:0] csrindex = '0;
  logic [63:0] csrdata = '0;
  logic        csren = 1'b0;
  logic        sfence_i = 1'b0;
  logic        sfence_rs1z_i = 1'b0;
  logic        sfence_rs2z_i = 1'b0;
  logic [63:0] sfence_vaddr_i = '0;
  logic [15:0] sfence_asid_i = '0;
  logic [63:0] satp;
  logic        busy_o;
  logic [1:0]  flush_req_o;
  logic        flush_all_o, flush_va_o, flush_asid_o;
  logic [63:0] flush_vaddr_o;
  logic [8:0]  flush_asidv_o;
  logic [1:0]  flush_ack_i = '0;

  virtual_trans_ctrl #(.ASID_WIDTH(9), .PPN_WIDTH(44), .NCH(2)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .valid(valid), .csrindex(csrindex),
    .csrdata(csrdata), .csren(csren), .sfence_i(sfence_i),
    .sfence_rs1z_i(sfence_rs1z_i), .sfence_rs2z_i(sfence_rs2z_i),
    .sfence_vaddr_i(sfence_vaddr_i), .sfence_asid_i(sfence_asid_i),
    .satp(satp), .busy_o(busy_o), .flush_req_o(flush_req_o),
    .flush_all_o(flush_all_o), .flush_va_o(flush_va_o), .flush_asid_o(flush_asid_o),
    .flush_vaddr_o(flush_vaddr_o), .flush_asidv_o(flush_asidv_o),
    .flush_ack_i(flush_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] satp;
    bit          all;
    bit          va;
    bit          asv;
    logic [63:0] vaddr;
    logic [15:0] asid;
  } exp_t;

  exp_t        q[$];
  logic [63:0] m_satp = '0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [3:0] m);
`ifdef VIRTUAL_TRANS_SV48_EN
    return (m == 4'd0) || (m == 4'd8) || (m == 4'd9);
`else
    return (m == 4'd0) || (m == 4'd8);
`endif
  endfunction

  function automatic logic [63:0] satp_after(input logic [63:0] cur, input logic [63:0] data);
    logic [3:0] m;
    m = data[63:60];
    if (!legal(m)) m = cur[63:60];
    return ({60'd0, m} << 60) | (((data >> 44) % 64'd512) << 44) | (data % (64'd1 << 44));
  endfunction

  // Called 1 ns after a rising edge; returns 1 ns after the edge that samples the commit.
  task automatic commit(input bit wr, input logic [63:0] data, input bit sf, input bit rs1z,
                        input bit rs2z, input logic [63:0] va, input logic [15:0] as);
    exp_t e;
    valid = 1'b1;
    csren = wr;
    csrindex = wr ? 12'h180 : 12'h300;
    csrdata = data;
    sfence_i = sf;
    sfence_rs1z_i = rs1z;
    sfence_rs2z_i = rs2z;
    sfence_vaddr_i = va;
    sfence_asid_i = as;
    if (wr) begin
      m_satp = satp_after(m_satp, data);
      e.all = 1'b1; e.va = 1'b0; e.asv = 1'b0;
    end else begin
      e.all = rs1z && rs2z; e.va = !rs1z; e.asv = !rs2z;
    end
    e.satp = m_satp;
    e.vaddr = va;
    e.asid = as % 16'd512;
    q.push_back(e);
    @(posedge clk_i); #1;
    valid = 1'b0; csren = 1'b0; sfence_i = 1'b0;
  endtask

  // Channel i acks in FLUSH cycle d[i]; inj drives an illegal commit in cycle 0.
  task automatic acks(input int d0, input int d1, input bit inj);
    int maxd;
    maxd = (d0 > d1) ? d0 : d1;
    for (int c = 0; c <= maxd; c++) begin
      flush_ack_i = {1'(d1 == c), 1'(d0 == c)};
      if (inj && c == 0) begin
        valid = 1'b1; csren = 1'b1; csrindex = 12'h180;
        csrdata = 64'h9000_ffff_ffff_ffff; sfence_i = 1'b1;
      end
      @(negedge clk_i);
      check("busy_during_flush", 64'(busy_o), 64'd1);
      check("req_pending", 64'(flush_req_o), 64'({1'(d1 >= c), 1'(d0 >= c)}));
      @(posedge clk_i); #1;
      valid = 1'b0; csren = 1'b0; sfence_i = 1'b0;
    end
    flush_ack_i = '0;
    @(negedge clk_i);
    check("busy_after_acks", 64'(busy_o), 64'd0);
    check("req_after_acks", 64'(flush_req_o), 64'd0);
    check("satp_after_flush", satp, m_satp);
    @(posedge clk_i); #1;
  endtask

  logic busy_prev = 1'b0;
  always @(negedge clk_i) begin
    exp_t e;
    if (arst_ni && busy_o && !busy_prev) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_flush: got busy 1 expected no flush (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        check("mon_satp", satp, e.satp);
        check("mon_req", 64'(flush_req_o), 64'd3);
        check("mon_all", 64'(flush_all_o), 64'(e.all));
        check("mon_va_v", 64'(flush_va_o), 64'(e.va));
        check("mon_asid_v", 64'(flush_asid_o), 64'(e.asv));
        if (e.va)  check("mon_vaddr", flush_vaddr_o, e.vaddr);
        if (e.asv) check("mon_asid", 64'(flush_asidv_o), 64'(e.asid));
      end
    end
    busy_prev = busy_o;
  end

  initial begin
    logic [63:0] data;
    logic [3:0]  modes[5];
    bit          wr, sf;

    #2;
    check("rst_satp", satp, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_req", 64'(flush_req_o), 64'd0);
    check("rst_qual", 64'({flush_all_o, flush_va_o, flush_asid_o}), 64'd0);
    check("rst_data", flush_vaddr_o | 64'(flush_asidv_o), 64'd0);
    @(negedge clk_i); arst_ni = 1'b1;
    @(posedge clk_i); #1;

    commit(1'b1, 64'h8000_0000_0008_0000, 1'b0, 1'b0, 1'b0, 64'd0, 16'd0);
    acks(0, 0, 1'b0);
    check("sv39_satp", satp, 64'h8000_0000_0008_0000);

    commit(1'b1, 64'h5000_0000_0000_0123, 1'b0, 1'b0, 1'b0, 64'd0, 16'd0);
    acks(1, 2, 1'b0);
    check("warl_mode5", satp, 64'h8000_0000_0000_0123);

    commit(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'h4000_1000, 16'd0);
    acks(1, 0, 1'b0);

    commit(1'b1, 64'h8000_0000_0000_0555, 1'b0, 1'b0, 1'b0, 64'd0, 16'd0);
    acks(0, 0, 1'b1);
    check("busy_commit_ignored", satp, 64'h8000_0000_0000_0555);

    commit(1'b1, 64'h9000_0000_0000_0777, 1'b0, 1'b0, 1'b0, 64'd0, 16'd0);
    acks(2, 0, 1'b0);
`ifdef VIRTUAL_TRANS_SV48_EN
    check("mode9", satp, 64'h9000_0000_0000_0777);
`else
    check("mode9", satp, 64'h8000_0000_0000_0777);
`endif

    commit(1'b1, 64'h8001_2300_0000_0abc, 1'b1, 1'b0, 1'b0, 64'h1234, 16'h0042);
    acks(0, 1, 1'b0);

    modes[0] = 4'd0; modes[1] = 4'd8; modes[2] = 4'd9; modes[3] = 4'd5;
    for (int i = 0; i < 40; i++) begin
      modes[4] = 4'($urandom_range(0, 15));
      data = {$urandom, $urandom};
      data[63:60] = modes[$urandom_range(0, 4)];
      wr = 1'($urandom_range(0, 1));
      sf = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      commit(wr, data, sf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, 16'($urandom));
      acks(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    commit(1'b1, 64'h8000_0000_0000_0abc, 1'b0, 1'b0, 1'b0, 64'd0, 16'd0);
    @(negedge clk_i);
    #2 arst_ni = 1'b0;
    #1;
    m_satp = '0;
    check("arst_satp", satp, 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_req", 64'(flush_req_o), 64'd0);
    check("arst_all", 64'(flush_all_o), 64'd0);
    @(posedge clk_i); #1;
    arst_ni = 1'b1;
    @(posedge clk_i); #1;

    commit(1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 64'd0, 16'h01ff);
    acks(0, 3, 1'b0);

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
